// File: rtl/riscv_pkg.sv
// Shared RV32 decode encodings: opcodes, immediate formats, ALU operations
// and result-source selects used by the decode stage and its helpers.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_COPYB = 4'd10;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

endpackage

// File: rtl/control_unit.sv
// Main decoder: maps opcode/funct fields to datapath control signals.
module control_unit
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic       reg_write,
  output logic [1:0] res_src,
  output logic       mem_write,
  output logic       jump,
  output logic       branch,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control
);

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                            input logic is_reg_op);
    case (f3)
      3'b000:  return (is_reg_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    reg_write   = 1'b0;
    res_src     = RES_ALU;
    mem_write   = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    case (opcode)
      OPC_LOAD:   begin reg_write = 1'b1; res_src = RES_MEM; alu_src_b = 1'b1; end
      OPC_STORE:  begin mem_write = 1'b1; alu_src_b = 1'b1; imm_src = IMM_S; end
      OPC_OP:     begin reg_write = 1'b1; alu_control = alu_decode(funct3, funct7b5, 1'b1); end
      OPC_OP_IMM: begin
        reg_write   = 1'b1;
        alu_src_b   = 1'b1;
        alu_control = alu_decode(funct3, funct7b5, 1'b0);
      end
      OPC_BRANCH: begin branch = 1'b1; imm_src = IMM_B; alu_control = ALU_SUB; end
      OPC_JAL:    begin reg_write = 1'b1; jump = 1'b1; res_src = RES_PC4; imm_src = IMM_J; end
      OPC_JALR:   begin reg_write = 1'b1; jump = 1'b1; res_src = RES_PC4; alu_src_b = 1'b1; end
      OPC_LUI:    begin
        reg_write = 1'b1; alu_src_b = 1'b1; imm_src = IMM_U; alu_control = ALU_COPYB;
      end
      OPC_AUIPC:  begin
        reg_write = 1'b1; alu_src_a = 1'b1; alu_src_b = 1'b1; imm_src = IMM_U;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_ext.sv
// Immediate extractor: assembles and sign-extends the I/S/B/J/U formats.
module imm_ext
  import riscv_pkg::*;
(
  input  logic [31:7] instr,
  input  logic [2:0]  imm_src,
  output logic [31:0] imm
);

  always_comb begin
    imm = {{20{instr[31]}}, instr[31:20]};
    case (imm_src)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_file_bypass.sv
// Two-read, one-write register file with x0 hard-wired to zero, out-of-range
// indices ignored, and optional write-through of the WB port onto the reads.
module reg_file_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [4:0]            wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [4:0]            ra1,
  input  logic [4:0]            ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int AW = $clog2(REG_COUNT);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  function automatic logic in_range(input logic [4:0] a);
    return {27'b0, a} < 32'(REG_COUNT);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && wa != '0 && in_range(wa)) begin
      regs[wa[AW-1:0]] <= wd;
    end
  end

  // Range check precedes the bypass compare, so a dropped write is never forwarded.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] a);
    if (a == '0 || !in_range(a)) return '0;
    if (BYPASS && we && wa == a) return wd;
    return regs[a[AW-1:0]];
  endfunction

  assign rd1 = read_port(ra1);
  assign rd2 = read_port(ra2);

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage with its own IF/ID register (stall/flush/valid), register file
// with WB bypass, RV32I/RV32E register-count checks and illegal-instruction flag.
module decode_stage_pipe
  import riscv_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_COUNT     = 32,
  parameter bit BYPASS        = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_d,
  input  logic                     flush_d,
  input  logic                     valid_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  input  logic [31:0]              instr_f,
  input  logic                     reg_write_w,
  input  logic [4:0]               rd_w,
  input  logic [DATA_WIDTH-1:0]    result_w,
  output logic                     valid_d,
  output logic                     illegal_d,
  output logic                     reg_write_d,
  output logic                     mem_write_d,
  output logic                     jump_d,
  output logic                     branch_d,
  output logic [1:0]               res_src_d,
  output logic [3:0]               alu_control_d,
  output logic                     alu_src_a_d,
  output logic                     alu_src_b_d,
  output logic [2:0]               funct3_d,
  output logic [4:0]               rs1_d,
  output logic [4:0]               rs2_d,
  output logic [4:0]               rd_d,
  output logic [DATA_WIDTH-1:0]    rd1_d,
  output logic [DATA_WIDTH-1:0]    rd2_d,
  output logic [DATA_WIDTH-1:0]    imm_val_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d
);

  logic        valid_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
    end else if (flush_d) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (!stall_d) begin
      valid_q    <= valid_f;
      instr_q    <= instr_f;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
    end
  end

  assign valid_d  = valid_q;
  assign funct3_d = instr_q[14:12];
  assign rs1_d    = instr_q[19:15];
  assign rs2_d    = instr_q[24:20];
  assign rd_d     = instr_q[11:7];

  logic       cu_reg_write, cu_mem_write, cu_jump, cu_branch;
  logic [2:0] imm_src;
  logic [31:0] imm32;

  control_unit u_control (
    .opcode      (instr_q[6:0]),
    .funct3      (instr_q[14:12]),
    .funct7b5    (instr_q[30]),
    .reg_write   (cu_reg_write),
    .res_src     (res_src_d),
    .mem_write   (cu_mem_write),
    .jump        (cu_jump),
    .branch      (cu_branch),
    .alu_src_a   (alu_src_a_d),
    .alu_src_b   (alu_src_b_d),
    .imm_src     (imm_src),
    .alu_control (alu_control_d)
  );

  imm_ext u_imm (
    .instr   (instr_q[31:7]),
    .imm_src (imm_src),
    .imm     (imm32)
  );

  assign imm_val_d = DATA_WIDTH'($signed(imm32));

  reg_file_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .BYPASS     (BYPASS)
  ) u_reg_file (
    .clk (clk),
    .rst_n (rst_n),
    .we  (reg_write_w),
    .wa  (rd_w),
    .wd  (result_w),
    .ra1 (rs1_d),
    .ra2 (rs2_d),
    .rd1 (rd1_d),
    .rd2 (rd2_d)
  );

  // Opcode legality and which register fields the format actually uses.
  logic opc_ok, use_rs1, use_rs2, use_rd, bad_reg;

  always_comb begin
    opc_ok  = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (instr_q[6:0])
      OPC_LOAD:   begin use_rs1 = 1'b1; use_rd = 1'b1; end
      OPC_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OP:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      OPC_OP_IMM: begin use_rs1 = 1'b1; use_rd = 1'b1; end
      OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_JAL:    use_rd = 1'b1;
      OPC_JALR:   begin use_rs1 = 1'b1; use_rd = 1'b1; end
      OPC_LUI:    use_rd = 1'b1;
      OPC_AUIPC:  use_rd = 1'b1;
      default:    opc_ok = 1'b0;
    endcase
  end

  assign bad_reg = (REG_COUNT == 16) &&
                   ((use_rs1 && rs1_d[4]) || (use_rs2 && rs2_d[4]) || (use_rd && rd_d[4]));

  assign illegal_d = valid_q && (!opc_ok || bad_reg);

  logic live;
  assign live        = valid_q && !illegal_d;
  assign reg_write_d = cu_reg_write && live;
  assign mem_write_d = cu_mem_write && live;
  assign jump_d      = cu_jump && live;
  assign branch_d    = cu_branch && live;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench: an RV32I/bypass instance and an RV32E/no-bypass instance share stimulus.
module tb_decode_stage_pipe;

  logic        clk, rst_n, stall_d, flush_d, valid_f, reg_write_w;
  logic [31:0] pc_f, pc_plus4_f, instr_f, result_w;
  logic [4:0]  rd_w;

  logic        valid_m, ill_m, rw_m, mw_m, jp_m, br_m, sa_m, sb_m;
  logic [1:0]  res_m;
  logic [3:0]  alu_m;
  logic [2:0]  f3_m;
  logic [4:0]  rs1_m, rs2_m, rdf_m;
  logic [31:0] rd1_m, rd2_m, imm_m, pc_m, pc4_m;

  logic        valid_e, ill_e, rw_e, mw_e, jp_e, br_e, sa_e, sb_e;
  logic [1:0]  res_e;
  logic [3:0]  alu_e;
  logic [2:0]  f3_e;
  logic [4:0]  rs1_e, rs2_e, rdf_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;

  decode_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .flush_d(flush_d), .valid_f(valid_f),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .instr_f(instr_f), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w), .valid_d(valid_m), .illegal_d(ill_m),
    .reg_write_d(rw_m), .mem_write_d(mw_m), .jump_d(jp_m), .branch_d(br_m),
    .res_src_d(res_m), .alu_control_d(alu_m), .alu_src_a_d(sa_m), .alu_src_b_d(sb_m),
    .funct3_d(f3_m), .rs1_d(rs1_m), .rs2_d(rs2_m), .rd_d(rdf_m), .rd1_d(rd1_m),
    .rd2_d(rd2_m), .imm_val_d(imm_m), .pc_d(pc_m), .pc_plus4_d(pc4_m)
  );

  decode_stage_pipe #(.REG_COUNT(16), .BYPASS(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .flush_d(flush_d), .valid_f(valid_f),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .instr_f(instr_f), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w), .valid_d(valid_e), .illegal_d(ill_e),
    .reg_write_d(rw_e), .mem_write_d(mw_e), .jump_d(jp_e), .branch_d(br_e),
    .res_src_d(res_e), .alu_control_d(alu_e), .alu_src_a_d(sa_e), .alu_src_b_d(sb_e),
    .funct3_d(f3_e), .rs1_d(rs1_e), .rs2_d(rs2_e), .rd_d(rdf_e), .rd1_d(rd1_e),
    .rd2_d(rd2_e), .imm_val_d(imm_e), .pc_d(pc_e), .pc_plus4_d(pc4_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    instr_f = instr; valid_f = 1'b1; pc_f = pc; pc_plus4_f = pc + 32'd4;
    step();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic rw, mw, jp, br;
    logic [1:0] res;
    logic [3:0] alu;
    logic sa, sb;
    logic [31:0] imm;
    logic ill, ill_e;
  } vec_t;

  vec_t vecs [14];

  initial begin
    //          instr         rw mw jp br res alu sa sb imm           ill ill_e
    vecs[0]  = '{32'h00500093, 1, 0, 0, 0, 0, 0,  0, 1, 32'h00000005, 0, 0}; // addi x1,x0,5
    vecs[1]  = '{32'h00528333, 1, 0, 0, 0, 0, 0,  0, 0, 32'h00000005, 0, 0}; // add x6,x5,x5
    vecs[2]  = '{32'h40B50533, 1, 0, 0, 0, 0, 1,  0, 0, 32'h0000040B, 0, 0}; // sub
    vecs[3]  = '{32'h4030D093, 1, 0, 0, 0, 0, 9,  0, 1, 32'h00000403, 0, 0}; // srai
    vecs[4]  = '{32'h0080A183, 1, 0, 0, 0, 1, 0,  0, 1, 32'h00000008, 0, 0}; // lw
    vecs[5]  = '{32'hFE20AE23, 0, 1, 0, 0, 0, 0,  0, 1, 32'hFFFFFFFC, 0, 0}; // sw -4
    vecs[6]  = '{32'h00208863, 0, 0, 0, 1, 0, 1,  0, 0, 32'h00000010, 0, 0}; // beq +16
    vecs[7]  = '{32'h0010006F, 1, 0, 1, 0, 2, 0,  0, 0, 32'h00000800, 0, 0}; // jal
    vecs[8]  = '{32'h123452B7, 1, 0, 0, 0, 0, 10, 0, 1, 32'h12345000, 0, 0}; // lui
    vecs[9]  = '{32'h00001397, 1, 0, 0, 0, 0, 0,  1, 1, 32'h00001000, 0, 0}; // auipc
    vecs[10] = '{32'h00008067, 1, 0, 1, 0, 2, 0,  0, 1, 32'h00000000, 0, 0}; // jalr
    vecs[11] = '{32'h0000007F, 0, 0, 0, 0, 0, 0,  0, 0, 32'h00000000, 1, 1}; // bad opcode
    vecs[12] = '{32'h014000B3, 1, 0, 0, 0, 0, 0,  0, 0, 32'h00000014, 0, 1}; // add x1,x0,x20
    vecs[13] = '{32'h00100813, 1, 0, 0, 0, 0, 0,  0, 1, 32'h00000001, 0, 1}; // addi x16

    rst_n = 1'b0; stall_d = 1'b0; flush_d = 1'b0; valid_f = 1'b0; reg_write_w = 1'b0;
    pc_f = '0; pc_plus4_f = '0; instr_f = '0; rd_w = '0; result_w = '0;
    #12;
    chk("reset_valid", {31'b0, valid_m}, 32'd0);
    chk("reset_valid_e", {31'b0, valid_e}, 32'd0);
    chk("reset_rw", {31'b0, rw_m}, 32'd0);
    chk("reset_ill", {31'b0, ill_m}, 32'd0);
    chk("reset_pc", pc_m, 32'd0);
    chk("reset_rd1", rd1_m, 32'd0);
    #5 rst_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      logic [31:0] pc;
      pc = 32'h100 + 32'(i) * 32'd4;
      load(vecs[i].instr, pc);
      chk($sformatf("v%0d_valid", i), {31'b0, valid_m}, 32'd1);
      chk($sformatf("v%0d_ill", i), {31'b0, ill_m}, {31'b0, vecs[i].ill});
      chk($sformatf("v%0d_rw", i), {31'b0, rw_m}, {31'b0, vecs[i].rw});
      chk($sformatf("v%0d_mw", i), {31'b0, mw_m}, {31'b0, vecs[i].mw});
      chk($sformatf("v%0d_jp", i), {31'b0, jp_m}, {31'b0, vecs[i].jp});
      chk($sformatf("v%0d_br", i), {31'b0, br_m}, {31'b0, vecs[i].br});
      chk($sformatf("v%0d_res", i), {30'b0, res_m}, {30'b0, vecs[i].res});
      chk($sformatf("v%0d_alu", i), {28'b0, alu_m}, {28'b0, vecs[i].alu});
      chk($sformatf("v%0d_srcs", i), {30'b0, sa_m, sb_m}, {30'b0, vecs[i].sa, vecs[i].sb});
      chk($sformatf("v%0d_imm", i), imm_m, vecs[i].imm);
      chk($sformatf("v%0d_fields", i), {12'b0, f3_m, rs1_m, rs2_m, rdf_m},
          {12'b0, vecs[i].instr[14:12], vecs[i].instr[19:15], vecs[i].instr[24:20],
           vecs[i].instr[11:7]});
      chk($sformatf("v%0d_pc", i), pc_m, pc);
      chk($sformatf("v%0d_pc4", i), pc4_m, pc + 32'd4);
      chk($sformatf("v%0d_ill_e", i), {31'b0, ill_e}, {31'b0, vecs[i].ill_e});
      chk($sformatf("v%0d_rw_e", i), {31'b0, rw_e}, {31'b0, vecs[i].rw & ~vecs[i].ill_e});
    end

    // Stall holds the slot for three cycles, then flush wins over stall.
    load(32'h00500093, 32'h200);
    instr_f = 32'h0000007F; pc_f = 32'h300; stall_d = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall%0d_valid", c), {31'b0, valid_m}, 32'd1);
      chk($sformatf("stall%0d_rd", c), {27'b0, rdf_m}, 32'd1);
      chk($sformatf("stall%0d_imm", c), imm_m, 32'd5);
      chk($sformatf("stall%0d_pc", c), pc_m, 32'h200);
      chk($sformatf("stall%0d_ill", c), {31'b0, ill_m}, 32'd0);
    end
    flush_d = 1'b1;
    step();
    chk("flush_valid", {31'b0, valid_m}, 32'd0);
    chk("flush_rw", {31'b0, rw_m}, 32'd0);
    chk("flush_ill", {31'b0, ill_m}, 32'd0);
    flush_d = 1'b0; stall_d = 1'b0;

    // Bypass: x5 = 0x11111111 lands on the same edge that loads add x6,x5,x5.
    reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'h11111111;
    load(32'h00528333, 32'h400);
    reg_write_w = 1'b0;
    #1;
    chk("byp_pre_rd1", rd1_m, 32'h11111111);
    chk("byp_pre_rd1_e", rd1_e, 32'h11111111);
    reg_write_w = 1'b1; result_w = 32'hDEADBEEF; stall_d = 1'b1;
    #1;
    chk("byp_on_rd1", rd1_m, 32'hDEADBEEF);
    chk("byp_on_rd2", rd2_m, 32'hDEADBEEF);
    chk("byp_off_rd1", rd1_e, 32'h11111111);
    chk("byp_off_rd2", rd2_e, 32'h11111111);
    step();
    reg_write_w = 1'b0;
    #1;
    chk("byp_stall_rd_hold", {27'b0, rdf_m}, 32'd6);
    chk("byp_next_rd1", rd1_m, 32'hDEADBEEF);
    chk("byp_next_rd1_e", rd1_e, 32'hDEADBEEF);
    chk("byp_next_rd2_e", rd2_e, 32'hDEADBEEF);
    stall_d = 1'b0;

    // x0 is never written nor bypassed.
    load(32'h00500093, 32'h500);
    reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'hFFFFFFFF;
    #1;
    chk("x0_byp_rd1", rd1_m, 32'd0);
    chk("x0_byp_rd1_e", rd1_e, 32'd0);
    step();
    reg_write_w = 1'b0;
    #1;
    chk("x0_after_rd1", rd1_m, 32'd0);

    // Index 20: stored on RV32I, dropped and read as zero on RV32E.
    reg_write_w = 1'b1; rd_w = 5'd20; result_w = 32'h0000AAAA;
    load(32'h014000B3, 32'h600);
    reg_write_w = 1'b0;
    #1;
    chk("x20_rd2", rd2_m, 32'h0000AAAA);
    chk("x20_rd2_e", rd2_e, 32'd0);
    chk("x20_ill_e", {31'b0, ill_e}, 32'd1);
    chk("x20_rw_e", {31'b0, rw_e}, 32'd0);

    // Asynchronous reset with a live instruction in the slot.
    load(32'h00528333, 32'h700);
    chk("rst_pre_valid", {31'b0, valid_m}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, valid_m}, 32'd0);
    chk("rst_async_valid_e", {31'b0, valid_e}, 32'd0);
    chk("rst_async_rw", {31'b0, rw_m}, 32'd0);
    chk("rst_async_rd1", rd1_m, 32'd0);
    step();
    #3 rst_n = 1'b1;
    load(32'h00528333, 32'h800);
    chk("rst_x5_rd1", rd1_m, 32'd0);
    chk("rst_x5_rd2_e", rd2_e, 32'd0);
    load(32'h014000B3, 32'h804);
    chk("rst_x20_rd2", rd2_m, 32'd0);
    chk("rst_valid_after", {31'b0, valid_m}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Registered successor to the combinational decode stage. It owns the IF/ID pipeline register with stall, flush and valid tracking, and contains a parametrised register file with WB-to-decode write-through bypass. It also selects RV32I or RV32E register count and flags illegal instructions. It sits between fetch and the ID/EX register, and reuses the existing control_unit and imm_ext blocks for field decode.

Parameters:
- ADDRESS_WIDTH, 32, PC width.
- DATA_WIDTH, 32, register/immediate width.
- REG_COUNT, 32, architectural registers; legal values are 32 (RV32I) and 16 (RV32E).
- BYPASS, 1, 1 = same-cycle WB write is visible on rd1_d/rd2_d; 0 = old value is read.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_d  in  1  hold the IF/ID register.
- flush_d  in  1  squash the IF/ID register to a bubble.
- valid_f  in  1  fetch presents a real instruction.
- pc_f  in  ADDRESS_WIDTH  fetch PC.
- pc_plus4_f  in  ADDRESS_WIDTH  fetch PC+4.
- instr_f  in  32  fetched instruction.
- reg_write_w  in  1  WB write enable.
- rd_w  in  5  WB destination register.
- result_w  in  DATA_WIDTH  WB data.
- valid_d  out  1  decode slot holds a live instruction.
- illegal_d  out  1  live instruction is unsupported.
- reg_write_d, mem_write_d, jump_d, branch_d  out  1 each  qualified control signals.
- res_src_d  out  2  result select.
- alu_control_d  out  4  ALU operation.
- alu_src_a_d, alu_src_b_d  out  1 each  ALU operand selects.
- funct3_d  out  3  instr[14:12].
- rs1_d, rs2_d, rd_d  out  5 each  register fields.
- rd1_d, rd2_d  out  DATA_WIDTH  register operands.
- imm_val_d  out  DATA_WIDTH  extended immediate.
- pc_d, pc_plus4_d  out  ADDRESS_WIDTH  registered PCs.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state:
  - IF/ID register holds instr = NOP (0x00000013), pc = 0, pc_plus4 = 0, valid = 0.
  - All register file entries are 0.
  - Outputs therefore come up as valid_d = 0, all qualified controls = 0, illegal_d = 0.
- Latency: inputs present at edge N with stall_d = 0 appear on *_d outputs after edge N. The latency is one cycle. rd1_d/rd2_d are combinational from the registered rs fields.
- Update priority each edge: flush_d beats stall_d, which beats load.
  - flush: valid = 0, instr = NOP; pc fields are don't-care but hold.
  - stall: all IF/ID fields hold.
  - load: capture valid_f, instr_f, pc_f, pc_plus4_f.
- A flush and a stall in the same cycle produce a flush.
- Qualification:
  - reg_write_d, mem_write_d, jump_d and branch_d equal the control_unit outputs ANDed with (valid_d & ~illegal_d).
  - Unqualified outputs (alu_control_d, imm_val_d, res_src_d, etc.) pass through unchanged.
- illegal_d is 1 when valid_d and any of the following holds:
  - opcode is not one of LOAD, STORE, OP, OP-IMM, BRANCH, JAL, JALR, LUI, AUIPC;
  - REG_COUNT = 16 and a used rs1/rs2/rd field has bit 4 set.
- Register file:
  - REG_COUNT x DATA_WIDTH entries, written at posedge when reg_write_w and rd_w != 0.
  - Writes with rd_w >= REG_COUNT are dropped.
  - Reads of x0, or of indices >= REG_COUNT, return 0.
- Bypass: when BYPASS = 1, reg_write_w is set, rd_w == rs and rs != 0, rdN_d = result_w in the same cycle. x0 is never bypassed.
- Simultaneous WB write and stall: the write completes, and the held instruction sees the new value on the next cycle regardless of BYPASS.
- Reset asserted mid-stall: the slot is cleared immediately, without waiting for a clock edge.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants;
  - NOP_INSTR;
  - imm_src encodings (3-bit);
  - ALU control codes (4-bit);
  - res_src codes.
- One new sub-module: reg_file_bypass, which carries the REG_COUNT and BYPASS parameters and implements x0 and range handling.
- control_unit and imm_ext are instantiated unchanged.

Test Plan:
- Load and decode: load 0x00500093 (addi x1,x0,5) with valid_f = 1 → next cycle valid_d = 1, reg_write_d = 1, rd_d = 1, rs1_d = 0, imm_val_d = 5, illegal_d = 0.
- Stall then flush: stall_d held 3 cycles with a new instr_f → outputs unchanged. Then flush_d = 1 together with stall_d = 1 → valid_d = 0 and reg_write_d = 0 next cycle.
- Bypass on: with BYPASS = 1, decode 0x00528333 (add x6,x5,x5) while reg_write_w = 1, rd_w = 5, result_w = 0xDEADBEEF → rd1_d = rd2_d = 0xDEADBEEF in the same cycle.
- Bypass off: repeat with BYPASS = 0 → old x5 value in that cycle, 0xDEADBEEF the next cycle.
- x0 protection: write rd_w = 0, result_w = 0xFFFFFFFF, then decode a read of x0 → rd1_d = 0. No bypass occurs.
- RV32E and illegal opcode: with REG_COUNT = 16, decode 0x014000B3 (add x1,x0,x20) → illegal_d = 1, reg_write_d = 0. Separately, instr 0x0000007F → illegal_d = 1.
- Reset mid-operation: assert rst_n = 0 mid-pipeline with a live instruction → valid_d = 0 immediately, without a clock edge. All registers read 0 after release.
